// File: rtl/policy_pkg.sv
// Shared types and constants for the policy generator family.
package policy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam logic [15:0] LFSR16_TAPS   = 16'hB400;
  localparam int unsigned NO_ACTION     = 0;

endpackage

// File: rtl/policy_lfsr.sv
// Galois LFSR (right-shifting) with synchronous seed load; a zero seed is forced to 1.
module policy_lfsr #(
  parameter int unsigned W    = 16,
  parameter logic [W-1:0] TAPS = W'(16'hB400),
  parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;
  logic [W-1:0] w_next;

  assign w_next = r_value[0] ? ((r_value >> 1) ^ TAPS) : (r_value >> 1);

  // Load wins over step so software can reseed at any time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_value <= SEED;
    end else if (load) begin
      r_value <= (seed == '0) ? W'(1) : seed;
    end else if (step) begin
      r_value <= w_next;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/policy_gen_seq.sv
// Sequential argmax policy generator: masked signed greedy scan or epsilon-greedy
// random legal pick, one Q-value per cycle, fixed N_ACT+1 cycle latency.
module policy_gen_seq
  import policy_pkg::*;
#(
  parameter int unsigned        N_ACT     = 9,
  parameter int unsigned        Q_W       = 18,
  parameter int unsigned        IDX_W     = 4,
  parameter int unsigned        EPS_W     = 8,
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = LFSR_W'(LFSR_SEED_DEF),
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = LFSR_W'(LFSR16_TAPS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_ACT*Q_W-1:0]   q_flat,
  input  logic [N_ACT-1:0]       valid_mask,
  input  logic [EPS_W-1:0]       epsilon,
  input  logic                   seed_load,
  input  logic [LFSR_W-1:0]      seed,
  output logic                   busy,
  output logic                   done,
  output logic [IDX_W-1:0]       next_action,
  output logic                   no_action,
  output logic                   explored
);

  localparam int unsigned IW1 = IDX_W + 1;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   w_accept;
  logic                   w_scan;
  logic                   w_finish;

  logic [LFSR_W-1:0]      w_lfsr;
  logic                   w_explore;
  logic [IW1-1:0]         w_off_raw;
  logic [IW1-1:0]         w_off;

  logic [N_ACT*Q_W-1:0]   r_q;
  logic [N_ACT-1:0]       r_mask;
  logic                   r_mode;
  logic [IDX_W-1:0]       r_offset;
  logic [IDX_W-1:0]       r_k;
  logic                   r_best_valid;
  logic [IDX_W-1:0]       r_best_idx;
  logic signed [Q_W-1:0]  r_best_q;

  logic [IW1-1:0]         w_sum;
  logic [IW1-1:0]         w_idx_wide;
  logic [IDX_W-1:0]       w_idx;
  logic signed [Q_W-1:0]  w_q_k;
  logic                   w_valid_k;
  logic                   w_take;

  logic                   r_busy;
  logic                   r_done;
  logic [IDX_W-1:0]       r_next_action;
  logic                   r_no_action;
  logic                   r_explored;

  policy_lfsr #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (w_accept),
    .load  (seed_load),
    .seed  (seed),
    .value (w_lfsr)
  );

  generate
    if (LFSR_W > EPS_W + IDX_W) begin : g_lfsr_spare
      logic w_lfsr_unused;
      assign w_lfsr_unused = ^w_lfsr[LFSR_W-1:EPS_W+IDX_W];
    end
  endgenerate

  // Mode and start offset are decided from the LFSR value present at the accepted start.
  assign w_explore = (w_lfsr[EPS_W-1:0] < epsilon);
  assign w_off_raw = {1'b0, w_lfsr[EPS_W+IDX_W-1:EPS_W]};
  assign w_off     = (w_off_raw >= IW1'(N_ACT)) ? (w_off_raw - IW1'(N_ACT)) : w_off_raw;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_scan      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SCAN;
          w_accept    = 1'b1;
        end
      end
      SCAN: begin
        w_scan = 1'b1;
        if (r_k == IDX_W'(N_ACT - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Index under examination: k in greedy mode, (offset + k) mod N_ACT when exploring.
  assign w_sum      = IW1'(r_offset) + IW1'(r_k);
  assign w_idx_wide = r_mode ? ((w_sum >= IW1'(N_ACT)) ? (w_sum - IW1'(N_ACT)) : w_sum)
                             : IW1'(r_k);
  assign w_idx      = IDX_W'(w_idx_wide);

  always_comb begin
    w_q_k     = '0;
    w_valid_k = 1'b0;
    for (int unsigned i = 0; i < N_ACT; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_q_k     = r_q[i*Q_W +: Q_W];
        w_valid_k = r_mask[i];
      end
    end
  end

  // Strict greater-than keeps the lower index on ties; explore keeps the first legal hit.
  assign w_take = w_valid_k &&
                  (r_mode ? !r_best_valid
                          : (!r_best_valid || (w_q_k > r_best_q)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q           <= '0;
      r_mask        <= '0;
      r_mode        <= 1'b0;
      r_offset      <= '0;
      r_k           <= '0;
      r_best_valid  <= 1'b0;
      r_best_idx    <= '0;
      r_best_q      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_next_action <= '0;
      r_no_action   <= 1'b0;
      r_explored    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_q          <= q_flat;
        r_mask       <= valid_mask;
        r_mode       <= w_explore;
        r_offset     <= IDX_W'(w_off);
        r_k          <= '0;
        r_best_valid <= 1'b0;
        r_best_idx   <= '0;
        r_best_q     <= '0;
      end
      if (w_scan) begin
        r_k <= r_k + IDX_W'(1);
        if (w_take) begin
          r_best_valid <= 1'b1;
          r_best_idx   <= w_idx;
          r_best_q     <= w_q_k;
        end
      end
      r_busy <= (w_state_nxt != IDLE);
      r_done <= w_finish;
      if (w_finish) begin
        r_next_action <= r_best_valid ? r_best_idx : IDX_W'(NO_ACTION);
        r_no_action   <= !r_best_valid;
        r_explored    <= r_mode;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign next_action = r_next_action;
  assign no_action   = r_no_action;
  assign explored    = r_explored;

endmodule

// File: tb/tb_policy_gen_seq.sv
// Directed and seeded-random checks of policy_gen_seq against a small reference model.
module tb_policy_gen_seq;

  localparam int unsigned N  = 9;
  localparam int unsigned QW = 18;
  localparam int unsigned IW = 4;
  localparam int unsigned EW = 8;
  localparam int unsigned LW = 16;

  typedef int qarr_t [9];

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N*QW-1:0] q_flat;
  logic [N-1:0]    valid_mask;
  logic [EW-1:0]   epsilon;
  logic            seed_load;
  logic [LW-1:0]   seed;
  logic            busy;
  logic            done;
  logic [IW-1:0]   next_action;
  logic            no_action;
  logic            explored;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] lf;
  int          n_expl;

  always #5 clk = ~clk;

  policy_gen_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .q_flat      (q_flat),
    .valid_mask  (valid_mask),
    .epsilon     (epsilon),
    .seed_load   (seed_load),
    .seed        (seed),
    .busy        (busy),
    .done        (done),
    .next_action (next_action),
    .no_action   (no_action),
    .explored    (explored)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] lf_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [N*QW-1:0] pack(input qarr_t v);
    logic [N*QW-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) r[i*QW +: QW] = QW'(v[i]);
    return r;
  endfunction

  // Returns the chosen index, or -1 when nothing is legal.
  function automatic int ref_pick(input logic [N*QW-1:0] qf, input logic [N-1:0] m,
                                  input bit ex, input int off);
    int best;
    int j;
    logic signed [QW-1:0] bq;
    logic signed [QW-1:0] qi;
    best = -1;
    bq   = '0;
    if (ex) begin
      for (int k = 0; k < 9; k++) begin
        j = (off + k) % 9;
        if (m[j] && best < 0) best = j;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        qi = qf[i*QW +: QW];
        if (m[i] && (best < 0 || qi > bq)) begin
          best = i;
          bq   = qi;
        end
      end
    end
    return best;
  endfunction

  task automatic decide(input string tag, input logic [N*QW-1:0] qf,
                        input logic [N-1:0] m, input logic [EW-1:0] eps);
    bit ex;
    int off;
    int exp;
    int lat;
    logic [IW-1:0] held;
    ex  = (lf[7:0] < eps);
    off = int'(lf[11:8]);
    if (off >= 9) off -= 9;
    exp = ref_pick(qf, m, ex, off);
    @(posedge clk); #1;
    q_flat = qf; valid_mask = m; epsilon = eps; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lf = lf_step(lf);
    q_flat = ~qf; valid_mask = ~m; epsilon = ~eps;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(10));
    if (done) begin
      chk({tag, "_idx"}, 32'(next_action), (exp < 0) ? 32'(0) : 32'(exp));
      chk({tag, "_noact"}, 32'(no_action), 32'(exp < 0));
      chk({tag, "_expl"}, 32'(explored), 32'(ex));
      chk({tag, "_busy"}, 32'(busy), 32'(0));
    end
    held = next_action;
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done), 32'(0));
    chk({tag, "_hold"}, 32'(next_action), 32'(held));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    qarr_t qa;
    qarr_t qn;
    qarr_t qb;
    int pulses;
    int first;
    int got;
    logic [N*QW-1:0] qr;
    logic [N-1:0]    mr;
    logic [15:0]     best_seed;
    logic [15:0]     w;
    logic [15:0]     v;
    int cnt;
    bit found;

    rst = 1'b0; start = 1'b0; seed_load = 1'b0; seed = '0;
    q_flat = '0; valid_mask = '0; epsilon = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_idx", 32'(next_action), 32'(0));
    chk("rst_noact", 32'(no_action), 32'(0));
    chk("rst_expl", 32'(explored), 32'(0));
    rst = 1'b1;
    lf  = 16'hACE1;

    qa = '{5, -3, 12, 12, 0, 7, -20, 1, 9};
    decide("greedy", pack(qa), 9'h1FF, 8'd0);
    chk("greedy_tie", 32'(next_action), 32'(2));
    chk("greedy_mode", 32'(explored), 32'(0));

    qn = '{-9, -2, -5, -7, -3, -8, -4, -6, -10};
    decide("neg", pack(qn), 9'b111111101, 8'd0);
    chk("neg_best", 32'(next_action), 32'(4));

    decide("none", pack(qa), 9'b0, 8'd0);
    chk("none_flag", 32'(no_action), 32'(1));
    chk("none_zero", 32'(next_action), 32'(0));

    @(posedge clk); #1;
    seed_load = 1'b1; seed = 16'h1234;
    @(posedge clk); #1;
    seed_load = 1'b0;
    lf = 16'h1234;
    decide("expl1", pack(qa), 9'b000010000, 8'd255);
    chk("expl1_flag", 32'(explored), 32'(1));
    chk("expl1_cell", 32'(next_action), 32'(4));
    decide("expl2", pack(qa), 9'b100000001, 8'd255);
    chk("expl2_legal", 32'(next_action == 0 || next_action == 8), 32'(1));

    // A zero seed must come up as 1: sample 1 is not below epsilon 1.
    @(posedge clk); #1;
    seed_load = 1'b1; seed = 16'h0000;
    @(posedge clk); #1;
    seed_load = 1'b0;
    lf = 16'h0001;
    decide("seed0", pack(qa), 9'h1FF, 8'd1);
    chk("seed0_mode", 32'(explored), 32'(0));

    // Mid-scan start, reseed and input change must not disturb the running decision.
    qb = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    @(posedge clk); #1;
    q_flat = pack(qa); valid_mask = 9'h1FF; epsilon = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; first = 0; got = -1;
    for (int c = 1; c <= 16; c++) begin
      if (c == 3) begin
        start = 1'b1; seed_load = 1'b1; seed = 16'h00FF; q_flat = pack(qb);
      end
      if (c == 4) begin
        start = 1'b0; seed_load = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first == 0) begin
          first = c;
          got   = int'(next_action);
        end
      end
    end
    lf = 16'h00FF;
    chk("mid_pulses", 32'(pulses), 32'(1));
    chk("mid_lat", 32'(first), 32'(10));
    chk("mid_idx", 32'(got), 32'(2));

    // All-ones sample never explores, even at the maximum epsilon.
    decide("ones", pack(qa), 9'h1FF, 8'd255);
    chk("ones_mode", 32'(explored), 32'(0));

    @(posedge clk); #1;
    q_flat = pack(qa); valid_mask = 9'h1FF; epsilon = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_idx", 32'(next_action), 32'(0));
    chk("abort_noact", 32'(no_action), 32'(0));
    chk("abort_expl", 32'(explored), 32'(0));
    rst = 1'b1;
    lf  = 16'hACE1;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'(0));
    decide("after", pack(qa), 9'h1FF, 8'd0);
    chk("after_idx", 32'(next_action), 32'(2));

    // Pick a seed whose next 1000 samples sit near the nominal 25% explore rate.
    best_seed = 16'h0001;
    found = 1'b0;
    for (int s = 1; s < 400 && !found; s++) begin
      v = 16'(s * 157 + 3);
      if (v != 16'h0000) begin
        cnt = 0;
        w = v;
        for (int i = 0; i < 1000; i++) begin
          if (w[7:0] < 8'd64) cnt++;
          w = lf_step(w);
        end
        if (cnt >= 235 && cnt <= 265) begin
          best_seed = v;
          found = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    seed_load = 1'b1; seed = best_seed;
    @(posedge clk); #1;
    seed_load = 1'b0;
    lf = best_seed;
    n_expl = 0;
    for (int i = 0; i < 1000; i++) begin
      for (int j = 0; j < 9; j++) qr[j*QW +: QW] = QW'($urandom);
      mr = 9'($urandom_range(1, 511));
      decide("rnd", qr, mr, 8'd64);
      chk("rnd_legal", 32'((next_action < 9) ? mr[next_action[3:0] % 9] : 1'b0), 32'(1));
      if (explored) n_expl++;
    end
    chk("rnd_rate", 32'(n_expl >= 220 && n_expl <= 280), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
